// File: rtl/multiplier_unsigned_seq.sv
// Sequential radix-2 shift-add unsigned multiplier with valid/ready handshakes.
// One multiplier bit is retired per RUN cycle, so latency is fixed at WIDTH+1 cycles.
module multiplier_unsigned_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_last_step;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     w_acc_step;
    logic [PW-1:0]     r_product;
    logic              r_ready;
    logic              r_valid;
    logic              r_busy;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; operands are only sampled from IDLE
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last_step  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == CW'(WIDTH - 1)) begin
                    w_last_step  = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        w_acc_step = r_acc;
        if (r_mplier[0]) begin
            w_acc_step = r_acc + r_mcand;
        end
    end

    // Datapath and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= PW'(i_multiplicand);
            r_mplier <= i_multiplier;
        end else if (r_state == S_RUN) begin
            r_count  <= r_count + CW'(1);
            r_acc    <= w_acc_step;
            r_mcand  <= {r_mcand[PW-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            if (w_last_step) begin
                r_product <= w_acc_step;
            end
        end
    end

    // Status outputs registered from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= (w_next_state == S_IDLE);
            r_valid <= (w_next_state == S_DONE);
            r_busy  <= (w_next_state == S_RUN);
        end
    end

    assign o_ready   = r_ready;
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;
    assign o_product = r_product;

endmodule
